// File: rtl/instr_fetch_queue.sv
// Instruction buffer between IF and decode: in-order FIFO of (instr, pc) with
// first-word fall-through, fetch back-pressure, flush shadow and sticky overflow.
module instr_fetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_valid,
  input  logic [DATA_W-1:0]         if_instr,
  input  logic [PC_W-1:0]           if_pc,
  output logic                      fetch_en,
  output logic                      dec_valid,
  output logic [DATA_W-1:0]         dec_instr,
  output logic [PC_W-1:0]           dec_pc,
  input  logic                      dec_ready,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] EN_LIMIT = CW'(DEPTH - 2);

  logic [DATA_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q    [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          shadow_q,   shadow_d;

  logic not_empty;
  logic is_full;
  logic fetch_live;
  logic pop;
  logic push;
  logic drop;

  assign not_empty  = (count_q != '0);
  assign is_full    = (count_q == FULL_CNT);
  // A fetch arriving in the cycle after a flush belongs to the old PC stream.
  assign fetch_live = if_valid & ~flush & ~shadow_q;
  assign pop        = not_empty & dec_ready & ~flush;
  assign push       = fetch_live & (~is_full | pop);
  assign drop       = fetch_live & is_full & ~pop;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    shadow_d   = 1'b0;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      shadow_d = 1'b1;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      shadow_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      shadow_q   <= shadow_d;
    end
  end

  // Storage is not reset; slots outside the occupied window are never observed.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      instr_mem_q[wr_ptr_q] <= if_instr;
      pc_mem_q[wr_ptr_q]    <= if_pc;
    end
  end

  assign fetch_en  = reset & ~flush & (count_q <= EN_LIMIT);
  assign dec_valid = not_empty;
  assign dec_instr = not_empty ? instr_mem_q[rd_ptr_q] : '0;
  assign dec_pc    = not_empty ? pc_mem_q[rd_ptr_q]    : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: reset, fill, full push+pop, overflow,
// flush shadow, mid-run reset and a short randomized run against a queue model.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [11:0] if_pc;
  logic        fetch_en;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [11:0] dec_pc;
  logic        dec_ready;
  logic        flush;
  logic [2:0]  count;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  instr_fetch_queue #(.DEPTH(4), .DATA_W(32), .PC_W(12)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .fetch_en(fetch_en), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .flush(flush), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    if_valid  = 1'b0;
    if_instr  = '0;
    if_pc     = '0;
    dec_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle();
    #1;
    compared++;
    if (fetch_en !== 1'b0) begin
      mismatched++; $display("FAIL rst_fetch_en_in_reset got=%b exp=0", fetch_en);
    end
    tick(); tick();
    reset = 1'b1;
    #1;
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL rst_count got=%0d exp=0", count); end
    compared++;
    if (dec_valid !== 1'b0) begin mismatched++; $display("FAIL rst_dec_valid got=%b exp=0", dec_valid); end
    compared++;
    if (dec_instr !== 32'h0) begin mismatched++; $display("FAIL rst_dec_instr got=%h exp=0", dec_instr); end
    compared++;
    if (dec_pc !== 12'h0) begin mismatched++; $display("FAIL rst_dec_pc got=%h exp=0", dec_pc); end
    compared++;
    if (fetch_en !== 1'b1) begin mismatched++; $display("FAIL rst_fetch_en got=%b exp=1", fetch_en); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_fill;
    logic exp_en;
    for (int i = 0; i < 4; i++) begin
      if_valid  = 1'b1;
      if_instr  = 32'hA0 + 32'(i);
      if_pc     = 12'(4 * i);
      dec_ready = 1'b0;
      #1;
      exp_en = (i <= 2);
      compared++;
      if (fetch_en !== exp_en) begin
        mismatched++; $display("FAIL fill_fetch_en[%0d] got=%b exp=%b", i, fetch_en, exp_en);
      end
      tick();
    end
    idle();
    #1;
    compared++;
    if (count !== 3'd4) begin mismatched++; $display("FAIL fill_count got=%0d exp=4", count); end
    compared++;
    if (fetch_en !== 1'b0) begin mismatched++; $display("FAIL fill_fetch_en_full got=%b exp=0", fetch_en); end
    compared++;
    if (dec_pc !== 12'h0) begin mismatched++; $display("FAIL fill_dec_pc got=%h exp=0", dec_pc); end
    compared++;
    if (dec_instr !== 32'hA0) begin mismatched++; $display("FAIL fill_dec_instr got=%h exp=a0", dec_instr); end
    compared++;
    if (dec_valid !== 1'b1) begin mismatched++; $display("FAIL fill_dec_valid got=%b exp=1", dec_valid); end
  endtask

  task automatic test_full_push_pop;
    if_valid  = 1'b1;
    if_instr  = 32'hA4;
    if_pc     = 12'd16;
    dec_ready = 1'b1;
    tick();
    idle();
    #1;
    compared++;
    if (count !== 3'd4) begin mismatched++; $display("FAIL fullpp_count got=%0d exp=4", count); end
    compared++;
    if (dec_instr !== 32'hA1) begin mismatched++; $display("FAIL fullpp_dec_instr got=%h exp=a1", dec_instr); end
    compared++;
    if (dec_pc !== 12'd4) begin mismatched++; $display("FAIL fullpp_dec_pc got=%0d exp=4", dec_pc); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL fullpp_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_i [4];
    exp_i[0] = 32'hA1; exp_i[1] = 32'hA2; exp_i[2] = 32'hA3; exp_i[3] = 32'hA4;
    if_valid  = 1'b1;
    if_instr  = 32'hB0;
    if_pc     = 12'h0B0;
    dec_ready = 1'b0;
    tick();
    idle();
    #1;
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    compared++;
    if (count !== 3'd4) begin mismatched++; $display("FAIL ovf_count got=%0d exp=4", count); end
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      compared++;
      if (dec_instr !== exp_i[i]) begin
        mismatched++; $display("FAIL ovf_drain_instr[%0d] got=%h exp=%h", i, dec_instr, exp_i[i]);
      end
      compared++;
      if (dec_pc !== 12'(4 * (i + 1))) begin
        mismatched++; $display("FAIL ovf_drain_pc[%0d] got=%0d exp=%0d", i, dec_pc, 4 * (i + 1));
      end
      tick();
    end
    idle();
    #1;
    compared++;
    if (dec_valid !== 1'b0) begin mismatched++; $display("FAIL ovf_empty_valid got=%b exp=0", dec_valid); end
    compared++;
    if (dec_instr !== 32'h0) begin mismatched++; $display("FAIL ovf_empty_instr got=%h exp=0", dec_instr); end
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      if_valid = 1'b1;
      if_instr = 32'hD0 + 32'(i);
      if_pc    = 12'h100 + 12'(4 * i);
      tick();
    end
    idle();
    #1;
    compared++;
    if (count !== 3'd3) begin mismatched++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
    flush     = 1'b1;
    if_valid  = 1'b1;
    if_instr  = 32'hDD;
    dec_ready = 1'b1;
    #1;
    compared++;
    if (fetch_en !== 1'b0) begin mismatched++; $display("FAIL flush_fetch_en got=%b exp=0", fetch_en); end
    tick();
    idle();
    if_valid = 1'b1;
    if_instr = 32'hC0;
    if_pc    = 12'h200;
    #1;
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL flush_count got=%0d exp=0", count); end
    compared++;
    if (dec_valid !== 1'b0) begin mismatched++; $display("FAIL flush_dec_valid got=%b exp=0", dec_valid); end
    tick();
    if_instr = 32'hC1;
    if_pc    = 12'h204;
    #1;
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL shadow_drop_count got=%0d exp=0", count); end
    tick();
    idle();
    #1;
    compared++;
    if (count !== 3'd1) begin mismatched++; $display("FAIL post_shadow_count got=%0d exp=1", count); end
    compared++;
    if (dec_instr !== 32'hC1) begin mismatched++; $display("FAIL post_shadow_instr got=%h exp=c1", dec_instr); end
    compared++;
    if (dec_pc !== 12'h204) begin mismatched++; $display("FAIL post_shadow_pc got=%h exp=204", dec_pc); end
    compared++;
    if (overflow !== 1'b1) begin mismatched++; $display("FAIL flush_keeps_ovf got=%b exp=1", overflow); end
  endtask

  task automatic test_flush_rearm;
    flush = 1'b1;
    tick();
    flush    = 1'b1;
    if_valid = 1'b1;
    if_instr = 32'hE5;
    tick();
    flush    = 1'b0;
    if_valid = 1'b1;
    if_instr = 32'hE6;
    if_pc    = 12'h300;
    tick();
    if_instr = 32'hE7;
    if_pc    = 12'h304;
    #1;
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL rearm_count got=%0d exp=0", count); end
    tick();
    idle();
    #1;
    compared++;
    if (dec_instr !== 32'hE7) begin mismatched++; $display("FAIL rearm_instr got=%h exp=e7", dec_instr); end
  endtask

  task automatic test_reset_mid;
    if_valid = 1'b1;
    if_instr = 32'hF8;
    if_pc    = 12'h308;
    tick();
    idle();
    #1;
    compared++;
    if (count !== 3'd2) begin mismatched++; $display("FAIL midrst_pre_count got=%0d exp=2", count); end
    reset = 1'b0;
    #1;
    compared++;
    if (fetch_en !== 1'b0) begin mismatched++; $display("FAIL midrst_fetch_en got=%b exp=0", fetch_en); end
    tick();
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL midrst_count got=%0d exp=0", count); end
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL midrst_overflow got=%b exp=0", overflow); end
    compared++;
    if (fetch_en !== 1'b0) begin mismatched++; $display("FAIL midrst_fetch_en_hold got=%b exp=0", fetch_en); end
    compared++;
    if (dec_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_dec_valid got=%b exp=0", dec_valid); end
    reset = 1'b1;
    #1;
    compared++;
    if (fetch_en !== 1'b1) begin mismatched++; $display("FAIL midrst_release_en got=%b exp=1", fetch_en); end
  endtask

  task automatic test_random;
    logic [31:0] q_instr [$];
    logic [11:0] q_pc    [$];
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    logic do_pop, do_push;
    while (recv < 8 && cycles < 300) begin
      dec_ready = 1'($urandom_range(0, 1));
      do_pop    = (q_instr.size() != 0) && dec_ready;
      do_push   = (sent < 8) && (q_instr.size() < 4 || do_pop) && ($urandom_range(0, 2) != 0);
      if_valid  = do_push;
      if_instr  = 32'h1000 + 32'(sent);
      if_pc     = 12'h400 + 12'(4 * sent);
      #1;
      compared++;
      if (count !== 3'(q_instr.size())) begin
        mismatched++; $display("FAIL rnd_count[c%0d] got=%0d exp=%0d", cycles, count, q_instr.size());
      end
      if (q_instr.size() != 0) begin
        compared++;
        if (dec_instr !== q_instr[0] || dec_pc !== q_pc[0]) begin
          mismatched++;
          $display("FAIL rnd_head[c%0d] got=%h/%h exp=%h/%h", cycles, dec_instr, dec_pc, q_instr[0], q_pc[0]);
        end
      end
      tick();
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
        recv++;
      end
      if (do_push) begin
        q_instr.push_back(if_instr);
        q_pc.push_back(if_pc);
        sent++;
      end
      cycles++;
    end
    idle();
    compared++;
    if (recv != 8) begin mismatched++; $display("FAIL rnd_timeout got=%0d exp=8", recv); end
    #1;
    compared++;
    if (overflow !== 1'b0) begin mismatched++; $display("FAIL rnd_overflow got=%b exp=0", overflow); end
    compared++;
    if (count !== 3'd0) begin mismatched++; $display("FAIL rnd_final_count got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_overflow();
    test_flush();
    test_flush_rearm();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
